serial_adder8: RTL and testbench
================================

SERIAL_ADDER8 -- requirements
Module: serial_adder8

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  operand A; sampled when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled when start is accepted.
REQ-007 c_in  input  1  carry-in; sampled when start is accepted.
REQ-008 sub  input  1  subtract select; the port exists only when SERIAL_SUB_EN is defined.
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  one-cycle pulse when a result becomes valid.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 c_out  output  1  registered carry out of the MSB.
REQ-013 ovf  output  1  registered signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-014 The block SHALL compute a + b + c_in bit-serially, LSB first, with one instance of the team's 1-bit full-adder cell (a, b, c_in -> sum, c_out) and a 1-bit carry register.
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 IDLE: start=1 at an edge SHALL load the A and B shift registers and the carry register (from a, b and c_in), clear the bit counter and enter SHIFT. start=0 SHALL keep the FSM in IDLE.
REQ-017 SHIFT: each edge SHALL feed the operand LSBs and the carry register to the FA cell, shift the FA sum bit into the MSB of the result shift register, store the FA c_out in the carry register, shift both operand registers right by one, and increment the counter.
REQ-018 On the WIDTH-th SHIFT edge, the FSM SHALL load sum, c_out and ovf from the final datapath values and enter DONE.
REQ-019 DONE: done=1 for exactly one cycle. On the next edge, start=1 SHALL be accepted as in IDLE; otherwise the FSM SHALL return to IDLE.
REQ-020 Latency: if start is accepted at edge E0, busy SHALL be 1 from E0 to E_WIDTH, and done SHALL be 1 for the cycle after E_WIDTH (for WIDTH=8: done is high after the 8th edge following E0).
REQ-021 start SHALL be ignored while in SHIFT; the operands and c_in SHALL also be ignored while in SHIFT.
REQ-022 sum, c_out and ovf SHALL update only on the completion edge, and SHALL hold their values through IDLE and any later SHIFT until the next completion.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 Arithmetic is modulo 2^WIDTH. The carry beyond the MSB appears only on c_out, and the block SHALL have no internal saturation.

Reset
REQ-025 reset=1 at an edge SHALL force the FSM to IDLE and clear busy, done, sum, c_out, ovf, the counter, the carry register and the shift registers to 0, regardless of state.
REQ-026 A reset during SHIFT SHALL abort the operation, and no done pulse SHALL be produced for it.
REQ-027 reset SHALL take priority over start on the same edge.

Configuration
REQ-028 Macro SERIAL_SUB_EN, when defined, SHALL add the sub port. When start is accepted with sub=1, the block SHALL latch ~b into the B register, force the carry register to 1 (ignoring c_in), and produce a - b, with c_out=1 meaning no borrow. When start is accepted with sub=0, the block SHALL behave exactly as the add-only build.
REQ-029 When SERIAL_SUB_EN is undefined, the sub port and its logic SHALL be absent, and the block SHALL perform addition only.

Verification
REQ-030 a=0x7F, b=0x01, c_in=0, start pulse -> after 8 edges sum=0x80, c_out=0, ovf=1; done is high for exactly one cycle; busy is high for 8 cycles.
REQ-031 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0; then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, ovf=0.
REQ-032 Start 0x12+0x34. Pulse start with a=0xAA, b=0x55 at SHIFT cycle 3 -> the result is still 0x46, c_out=0, and exactly one done pulse occurs.
REQ-033 Start 0x10+0x10, and assert reset at SHIFT cycle 4 -> the next cycle shows busy=0, done=0, sum=0x00, state IDLE; no done pulse follows.
REQ-034 Back-to-back: start held high through DONE -> the second operation begins on the DONE edge, and done pulses every 9 cycles.
REQ-035 SERIAL_SUB_EN defined, sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.

Source files
------------

// File: rtl/serial_adder8_if.sv
// Operand/result bundle for the bit-serial adder.
// The master side drives start and the operands; the slave side returns status and result.
// The subtract select exists only when SERIAL_SUB_EN is defined.
interface serial_adder8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

`ifdef SERIAL_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`endif
endinterface

// File: rtl/serial_adder8.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first; optional subtract (SERIAL_SUB_EN).
// Latency: start accepted at E0, busy through E_WIDTH, done pulses the cycle after E_WIDTH.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while shifting.

// 1-bit full-adder cell.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder8_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [WIDTH-1:0] res_sr_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             last_bit;

  // Subtraction is a + ~b + 1, so only the B load value and initial carry change.
`ifdef SERIAL_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1   : bus.c_in;
`else
  assign b_load = bus.b;
  assign c_load = bus.c_in;
`endif

  fa_cell u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign res_sr_d = (res_sr_q >> 1) | ({{(WIDTH-1){1'b0}}, fa_s} << (WIDTH-1));
  assign last_bit = (cnt_q == CW'(WIDTH-1));

  // Control FSM and serial datapath; all outputs registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_sr_d;
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            sum_q   <= res_sr_d;
            c_out_q <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder8.sv
// Directed bench for serial_adder8: latency, arithmetic, start-ignore, reset abort, back-to-back.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Subtraction vectors run only when SERIAL_SUB_EN is defined.
module tb_serial_adder8;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   overlap = 0;
  logic [7:0] prev_sum = 8'h00;
  logic sub_sel = 1'b0;

  serial_adder8_if #(.WIDTH(8)) bus ();
  serial_adder8 #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // busy and done must never coincide.
  always @(negedge clk) if (bus.busy && bus.done) overlap++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.c_in  = tci;
`ifdef SERIAL_SUB_EN
    bus.sub   = sub_sel;
`endif
  endtask

  // One complete operation with latency, busy-length and result checks.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic [7:0] es, input logic eco, input logic eovf, input string tag);
    int busy_cnt = 0;
    int n = 0;
    @(negedge clk);
    drive_start(ta, tb_v, tci);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.c_in = 1'($urandom);
    chk({tag, "_hold"}, {8'h0, bus.sum}, {8'h0, prev_sum});
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 16'(n), 16'd8);
    chk({tag, "_busycyc"}, 16'(busy_cnt), 16'd8);
    chk({tag, "_sum"}, {8'h0, bus.sum}, {8'h0, es});
    chk({tag, "_cout"}, {15'h0, bus.c_out}, {15'h0, eco});
    chk({tag, "_ovf"}, {15'h0, bus.ovf}, {15'h0, eovf});
    prev_sum = es;
    @(negedge clk);
    chk({tag, "_donepulse"}, {15'h0, bus.done}, 16'h0);
  endtask

  initial begin
    int done_cnt;
    int d1;
    int d2;
    logic [7:0] s1;
    logic [7:0] s2;
    logic busy_after;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.c_in = 1'b0;
`ifdef SERIAL_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", {15'h0, bus.busy}, 16'h0);
    chk("rst_done", {15'h0, bus.done}, 16'h0);
    chk("rst_sum", {8'h0, bus.sum}, 16'h0);
    chk("rst_cout", {15'h0, bus.c_out}, 16'h0);
    chk("rst_ovf", {15'h0, bus.ovf}, 16'h0);

    // Reset wins over start on the same edge.
    drive_start(8'h11, 8'h22, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("rstprio_busy", {15'h0, bus.busy}, 16'h0);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("rstprio_nodone", 16'(done_cnt), 16'd0);

    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add7f01");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "addff01");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "addffff1");
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add8080");
    run_op(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, "add55aa1");
    run_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, "add3c0f1");

    // start and operands are ignored mid-operation.
    @(negedge clk);
    drive_start(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    drive_start(8'hAA, 8'h55, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0;
    s1 = 8'h00;
    d1 = 0;
    repeat (15) begin
      if (bus.done) begin
        done_cnt++;
        s1 = bus.sum;
        d1 = int'(bus.c_out);
      end
      @(negedge clk);
    end
    chk("ignore_donecnt", 16'(done_cnt), 16'd1);
    chk("ignore_sum", {8'h0, s1}, 16'h46);
    chk("ignore_cout", 16'(d1), 16'd0);

    // Reset during SHIFT aborts without a done pulse.
    drive_start(8'h10, 8'h10, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {15'h0, bus.busy}, 16'h0);
    chk("abort_done", {15'h0, bus.done}, 16'h0);
    chk("abort_sum", {8'h0, bus.sum}, 16'h0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("abort_nodone", 16'(done_cnt), 16'd0);
    prev_sum = 8'h00;

    // Back-to-back with start held high through DONE.
    drive_start(8'h01, 8'h02, 1'b0);
    done_cnt = 0;
    d1 = -1; d2 = -1; s1 = 8'h00; s2 = 8'h00;
    busy_after = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.a = 8'h03;
        bus.b = 8'h04;
      end
      if (cyc == d1 + 1 && d1 >= 0) busy_after = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin d1 = cyc; s1 = bus.sum; end
        if (done_cnt == 2) begin d2 = cyc; s2 = bus.sum; bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_at", 16'(d1), 16'd8);
    chk("b2b_gap", 16'(d2 - d1), 16'd9);
    chk("b2b_donecnt", 16'(done_cnt), 16'd2);
    chk("b2b_busy_after_done", {15'h0, busy_after}, 16'h1);
    chk("b2b_sum1", {8'h0, s1}, 16'h03);
    chk("b2b_sum2", {8'h0, s2}, 16'h07);
    prev_sum = 8'h07;

`ifdef SERIAL_SUB_EN
    sub_sel = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub0507");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub8001");
    run_op(8'h09, 8'h09, 1'b0, 8'h00, 1'b1, 1'b0, "sub0909");
    sub_sel = 1'b0;
    run_op(8'h05, 8'h07, 1'b1, 8'h0D, 1'b0, 1'b0, "sub0add");
`endif

    chk("busy_done_overlap", 16'(overlap), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
